// File: rtl/i2s_pkg.sv
// Shared constants and state encoding for the I2S receive path.
package i2s_pkg;

    localparam int DATA_WIDTH_DEF = 24;

    typedef enum logic [1:0] {
        SEEK  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } rx_state_t;

endpackage

// File: rtl/i2s_sync.sv
// Multi-stage synchronizer for one asynchronous input, with a registered
// level and a registered rising-edge strobe that line up in time.
module i2s_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            sync_q <= (sync_q << 1) | STAGES'(din);
            level  <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~level;
        end
    end

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sclk/lrck/sdata on clk and emits one stereo pair
// per valid pulse.
//
//   state | meaning
//   SEEK  | after reset; wait for first right->left boundary, capture nothing
//   LEFT  | collecting a left word
//   RIGHT | collecting a right word; its completion publishes the pair
module i2s_rx
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx_sclk,
    input  logic                  rx_lrck,
    input  logic                  rx_sdata,
    output logic [DATA_WIDTH-1:0] l_data,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  valid,
    output logic                  frame_err
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [DATA_WIDTH-1:0] MSB_ONE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic sclk_rise, lrck_lvl, sdata_lvl;
    logic unused_sclk_lvl, unused_lrck_rise, unused_sdata_rise;

    i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .din(rx_sclk),
        .level(unused_sclk_lvl), .rise(sclk_rise)
    );
    i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_lrck (
        .clk(clk), .reset_n(reset_n), .din(rx_lrck),
        .level(lrck_lvl), .rise(unused_lrck_rise)
    );
    i2s_sync #(.STAGES(SYNC_STAGES)) u_sync_sdata (
        .clk(clk), .reset_n(reset_n), .din(rx_sdata),
        .level(sdata_lvl), .rise(unused_sdata_rise)
    );

    rx_state_t             state;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] hold;
    logic                  lrck_last;

    logic                  boundary;
    logic                  short_word;
    logic [DATA_WIDTH-1:0] word_done;

    // The bit pointer walks MSB to LSB; once saturated it selects nothing,
    // so surplus bits fall away and short words stay left-justified.
    always_comb begin
        boundary   = sclk_rise && (lrck_lvl != lrck_last);
        short_word = bit_cnt < CW'(DATA_WIDTH - 1);
        word_done  = shreg | (sdata_lvl ? (MSB_ONE >> bit_cnt) : '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= SEEK;
            bit_cnt   <= '0;
            shreg     <= '0;
            hold      <= '0;
            lrck_last <= 1'b0;
            l_data    <= '0;
            r_data    <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (sclk_rise) begin
                lrck_last <= lrck_lvl;
                if (boundary) begin
                    // The boundary bit still belongs to the word just ending.
                    bit_cnt <= '0;
                    shreg   <= '0;
                    case (state)
                        SEEK: begin
                            if (!lrck_lvl) state <= LEFT;
                        end
                        LEFT: begin
                            hold      <= word_done;
                            frame_err <= frame_err | short_word;
                            state     <= RIGHT;
                        end
                        RIGHT: begin
                            l_data    <= hold;
                            r_data    <= word_done;
                            valid     <= 1'b1;
                            frame_err <= frame_err | short_word;
                            state     <= LEFT;
                        end
                        default: state <= SEEK;
                    endcase
                end else if (bit_cnt != CW'(DATA_WIDTH)) begin
                    shreg   <= word_done;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: serial BFM drives L/R words, a scoreboard queue holds the
// expected pairs and a monitor pops one entry per valid pulse.
module tb_i2s_rx;
    import i2s_pkg::*;

    localparam int SCLK_H = 160;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rx_sclk, rx_lrck, rx_sdata;
    logic [23:0] l_data, r_data;
    logic        valid, frame_err;

    i2s_rx #(.DATA_WIDTH(24), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_sclk(rx_sclk), .rx_lrck(rx_lrck), .rx_sdata(rx_sdata),
        .l_data(l_data), .r_data(r_data), .valid(valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] l;
        logic [23:0] r;
        logic        err;
    } exp_t;

    typedef struct {
        logic [31:0] lbits;
        int          lslots;
        logic [31:0] rbits;
        int          rslots;
        logic [23:0] exp_l;
        logic [23:0] exp_r;
        logic        exp_err;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        vecs[5];
    int          checks = 0;
    int          errors = 0;
    int          n_valid = 0;
    int          v0;
    logic        pending = 1'b0;
    logic        valid_prev = 1'b0;
    logic [23:0] l_hold = '0;
    logic [23:0] r_hold = '0;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One I2S word of 'slots' sclk periods; the first period carries the
    // last bit of the previous word, the rest carry bits MSB first.
    task automatic send_word(input logic lr, input logic [31:0] bits, input int slots);
        for (int j = 0; j < slots; j++) begin
            rx_sclk  = 1'b0;
            rx_lrck  = lr;
            rx_sdata = (j == 0) ? pending : bits[32-j];
            #SCLK_H;
            rx_sclk = 1'b1;
            #SCLK_H;
        end
        pending = bits[32-slots];
    endtask

    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l_hold     = '0;
            r_hold     = '0;
            valid_prev = 1'b0;
        end else begin
            if (valid) begin
                n_valid++;
                chk("valid_width", 48'(valid_prev), 48'd0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid actual=%h/%h required=none", l_data, r_data);
                end else begin
                    mon_e = sb.pop_front();
                    chk("l_data", 48'(l_data), 48'(mon_e.l));
                    chk("r_data", 48'(r_data), 48'(mon_e.r));
                    chk("frame_err", 48'(frame_err), 48'(mon_e.err));
                end
                l_hold = l_data;
                r_hold = r_data;
            end else begin
                chk("hold_stable", {l_data, r_data}, {l_hold, r_hold});
            end
            valid_prev = valid;
        end
    end

    initial begin
        vecs[0] = '{32'hABCDEF00, 24, 32'h12345600, 24, 24'hABCDEF, 24'h123456, 1'b0};
        vecs[1] = '{32'h00000000, 24, 32'hFFFFFF00, 24, 24'h000000, 24'hFFFFFF, 1'b0};
        vecs[2] = '{32'h80000100, 32, 32'h7FFFFE00, 32, 24'h800001, 24'h7FFFFE, 1'b0};
        vecs[3] = '{32'hFFFF0000, 16, 32'hA5A5A500, 24, 24'hFFFF00, 24'hA5A5A5, 1'b1};
        vecs[4] = '{32'h5A5A5A00, 24, 32'h0F0F0F00, 24, 24'h5A5A5A, 24'h0F0F0F, 1'b1};

        reset_n  = 1'b0;
        rx_sclk  = 1'b0;
        rx_lrck  = 1'b0;
        rx_sdata = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_l_data", 48'(l_data), 48'd0);
        chk("rst_r_data", 48'(r_data), 48'd0);
        chk("rst_valid", 48'(valid), 48'd0);
        chk("rst_frame_err", 48'(frame_err), 48'd0);
        chk("rst_state", 48'(dut.state), 48'(SEEK));
        reset_n = 1'b1;
        repeat (3) @(posedge clk);

        // Back-to-back frames, including oversize and short words.
        v0 = n_valid;
        send_word(1'b1, 32'h0, 24);
        for (int i = 0; i < 5; i++) begin
            sb.push_back(exp_t'{l: vecs[i].exp_l, r: vecs[i].exp_r, err: vecs[i].exp_err});
            send_word(1'b0, vecs[i].lbits, vecs[i].lslots);
            send_word(1'b1, vecs[i].rbits, vecs[i].rslots);
        end
        send_word(1'b0, 32'h0, 24);
        chk("pair_count", 48'(n_valid - v0), 48'd5);
        chk("sb_drained", 48'(sb.size()), 48'd0);
        chk("err_sticky", 48'(frame_err), 48'd1);

        // Short asynchronous reset pulse between clock edges.
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("pulse_l_data", 48'(l_data), 48'd0);
        chk("pulse_r_data", 48'(r_data), 48'd0);
        chk("pulse_valid", 48'(valid), 48'd0);
        chk("pulse_frame_err", 48'(frame_err), 48'd0);
        chk("pulse_state", 48'(dut.state), 48'(SEEK));
        reset_n = 1'b1;
        v0 = n_valid;
        send_word(1'b1, 32'h13579B00, 24);
        send_word(1'b0, 32'h2468AC00, 24);
        send_word(1'b1, 32'hFEDCBA00, 24);
        chk("seek_no_valid", 48'(n_valid - v0), 48'd0);

        // Reset released in the middle of a right word.
        reset_n = 1'b0;
        sb.delete();
        v0 = n_valid;
        fork
            begin
                send_word(1'b0, 32'h11111100, 24);
                send_word(1'b1, 32'h22222200, 24);
            end
            begin
                #(2 * SCLK_H * 34);
                reset_n = 1'b1;
            end
        join
        sb.push_back(exp_t'{l: 24'h333333, r: 24'h444444, err: 1'b0});
        send_word(1'b0, 32'h33333300, 24);
        send_word(1'b1, 32'h44444400, 24);
        send_word(1'b0, 32'h0, 24);
        chk("midrst_pairs", 48'(n_valid - v0), 48'd1);
        chk("midrst_sb_drained", 48'(sb.size()), 48'd0);
        chk("midrst_frame_err", 48'(frame_err), 48'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
